// File: rtl/clk_div_pkg.sv
// Shared state encoding and parameter defaults for the clock-divider scheduler.
package clk_div_pkg;
    localparam int DEF_CNT_W       = 8;
    localparam int DEF_DIV_DEFAULT = 15;
    localparam int DEF_DIV_MIN     = 2;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_PEND
    } state_t;
endpackage

// File: rtl/clk_div_core.sv
// Period counter and divided-clock waveform generator for clk_div_sched.
// CLK_DIV_DUTY50_EN adds a negedge flop so odd ratios get exact 50% duty.
module clk_div_core
    import clk_div_pkg::*;
#(
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run,
    input  logic             enable,
    input  logic [CNT_W-1:0] div_cur,
    output logic             clk_out,
    output logic             tick,
    output logic             wrap
);
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;
    logic             going;

    // going: divider is running in the cycle after this edge (stop only at a wrap)
    assign wrap     = run && (cnt == div_cur - CNT_W'(1));
    assign going    = run ? !(wrap && !enable) : enable;
    assign cnt_next = (!run || wrap) ? '0 : cnt + CNT_W'(1);

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt  <= '0;
            tick <= 1'b0;
        end else begin
            cnt  <= cnt_next;
            tick <= going && (cnt_next == '0);
        end
    end

`ifdef CLK_DIV_DUTY50_EN
    logic h_pos;
    logic h_neg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_pos <= 1'b0;
        end else begin
            h_pos <= going && (cnt_next < (div_cur >> 1));
        end
    end

    // Half-cycle extension only for odd ratios.
    always_ff @(negedge clk) begin
        if (!rst) begin
            h_neg <= 1'b0;
        end else begin
            h_neg <= h_pos && div_cur[0];
        end
    end

    assign clk_out = h_pos | h_neg;
`else
    logic [CNT_W:0] half;
    logic           clk_q;

    assign half = ({1'b0, div_cur} + (CNT_W+1)'(1)) >> 1;

    always_ff @(posedge clk) begin
        if (!rst) begin
            clk_q <= 1'b0;
        end else begin
            clk_q <= going && ({1'b0, cnt_next} < half);
        end
    end

    assign clk_out = clk_q;
`endif
endmodule

// File: rtl/clk_div_sched.sv
// Divide-ratio owner and start/stop sequencer for the clock divider; ratio
// changes land only on period boundaries. Optional feature: CLK_DIV_DUTY50_EN.
module clk_div_sched
    import clk_div_pkg::*;
#(
    parameter int CNT_W       = DEF_CNT_W,
    parameter int DIV_DEFAULT = DEF_DIV_DEFAULT,
    parameter int DIV_MIN     = DEF_DIV_MIN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             div_req_valid,
    output logic             div_req_ready,
    input  logic [CNT_W-1:0] div_req_val,
    output logic             clk_out,
    output logic             tick,
    output logic [CNT_W-1:0] div_cur,
    output logic             busy,
    output logic             err_ratio
);
    // state | meaning
    // IDLE  | divider stopped, clk_out low, requests applied directly
    // RUN   | dividing with div_cur, no request outstanding
    // PEND  | dividing, accepted ratio waits in pending for the next wrap
    state_t           state;
    logic [CNT_W-1:0] pending;
    logic             wrap;
    logic             accept;
    logic             bad;

    assign accept = div_req_valid && div_req_ready;
    assign bad    = div_req_val < CNT_W'(DIV_MIN);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state         <= ST_IDLE;
            div_cur       <= CNT_W'(DIV_DEFAULT);
            pending       <= '0;
            div_req_ready <= 1'b0;
            busy          <= 1'b0;
            err_ratio     <= 1'b0;
        end else begin
            err_ratio <= accept && bad;
            case (state)
                ST_IDLE: begin
                    div_req_ready <= 1'b1;
                    if (accept && !bad) begin
                        div_cur <= div_req_val;
                    end
                    if (enable) begin
                        state <= ST_RUN;
                        busy  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (wrap && !enable) begin
                        state         <= ST_IDLE;
                        busy          <= 1'b0;
                        div_req_ready <= 1'b1;
                        if (accept && !bad) begin
                            div_cur <= div_req_val;
                        end
                    end else if (accept && !bad) begin
                        pending       <= div_req_val;
                        state         <= ST_PEND;
                        div_req_ready <= 1'b0;
                    end else begin
                        div_req_ready <= 1'b1;
                    end
                end
                ST_PEND: begin
                    if (wrap) begin
                        div_cur       <= pending;
                        div_req_ready <= 1'b1;
                        if (enable) begin
                            state <= ST_RUN;
                        end else begin
                            state <= ST_IDLE;
                            busy  <= 1'b0;
                        end
                    end else begin
                        div_req_ready <= 1'b0;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    busy          <= 1'b0;
                    div_req_ready <= 1'b1;
                end
            endcase
        end
    end

    clk_div_core #(
        .CNT_W (CNT_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .run     (busy),
        .enable  (enable),
        .div_cur (div_cur),
        .clk_out (clk_out),
        .tick    (tick),
        .wrap    (wrap)
    );
endmodule

// File: tb/tb_clk_div_sched.sv
// Scoreboard bench for clk_div_sched: stimulus pushes the expected ratio of each
// output period, a monitor measures every period and compares.
module tb_clk_div_sched;
    localparam int NPER = 60;

    logic       clk;
    logic       rst;
    logic       enable;
    logic       div_req_valid;
    logic       div_req_ready;
    logic [7:0] div_req_val;
    logic       clk_out;
    logic       tick;
    logic [7:0] div_cur;
    logic       busy;
    logic       err_ratio;

    int n_cmp;
    int n_bad;
    int exp_q[$];

    int m_cur;
    bit sched;
    int sched_val;
    int sched_p;

    bit mon_open;
    int mon_hi;
    int mon_lo;
    int mon_dc;
    bit mon_shape_bad;
    bit mon_dc_bad;

    clk_div_sched dut (
        .clk           (clk),
        .rst           (rst),
        .enable        (enable),
        .div_req_valid (div_req_valid),
        .div_req_ready (div_req_ready),
        .div_req_val   (div_req_val),
        .clk_out       (clk_out),
        .tick          (tick),
        .div_cur       (div_cur),
        .busy          (busy),
        .err_ratio     (err_ratio)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic wait_tick();
        int n;
        n = 0;
        while (!tick && n < 600) begin
            step();
            n++;
        end
        check("tick_wait", int'(tick), 1);
    endtask

    task automatic do_good_req(input int k, input int val, input int p);
        repeat (k) step();
        check("ready_before_req", int'(div_req_ready), 1);
        div_req_valid = 1'b1;
        div_req_val   = 8'(val);
        step();
        div_req_valid = 1'b0;
        check("ready_in_pend", int'(div_req_ready), 0);
        check("div_cur_hold", int'(div_cur), m_cur);
        sched     = 1'b1;
        sched_val = val;
        sched_p   = (k < m_cur - 1) ? p + 1 : p + 2;
    endtask

    task automatic do_bad_req(input int k, input int val);
        repeat (k) step();
        check("ready_before_bad", int'(div_req_ready), 1);
        div_req_valid = 1'b1;
        div_req_val   = 8'(val);
        step();
        div_req_valid = 1'b0;
        check("err_pulse", int'(err_ratio), 1);
        check("ready_after_bad", int'(div_req_ready), 1);
        step();
        check("err_single", int'(err_ratio), 0);
        check("div_cur_after_bad", int'(div_cur), m_cur);
    endtask

    task automatic do_stop(input int k);
        int n;
        repeat (k) step();
        enable = 1'b0;
        n = 0;
        while (busy && n < 600) begin
            step();
            n++;
        end
        check("stop_cycles", n, m_cur - k);
        check("stop_clk_out", int'(clk_out), 0);
        if (sched) begin
            m_cur = sched_val;
            sched = 1'b0;
        end
        check("idle_div_cur", int'(div_cur), m_cur);
    endtask

    task automatic do_idle_req(input int v);
        check("ready_idle", int'(div_req_ready), 1);
        div_req_valid = 1'b1;
        div_req_val   = 8'(v);
        step();
        div_req_valid = 1'b0;
        if (v < 2) check("idle_err_pulse", int'(err_ratio), 1);
        else m_cur = v;
        check("idle_div_cur_upd", int'(div_cur), m_cur);
    endtask

    task automatic do_restart();
        enable = 1'b1;
        step();
        check("restart_tick", int'(tick), 1);
        check("restart_busy", int'(busy), 1);
        check("restart_clk_out", int'(clk_out), 1);
    endtask

    // Monitor: measures each output period between ticks (or until busy drops).
    initial begin
        int n;
        mon_open = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (mon_open && exp_q.size() > 0) void'(exp_q.pop_front());
                mon_open = 1'b0;
            end else begin
                if (mon_open && (tick || !busy)) begin
                    check("period_expected", int'(exp_q.size() > 0), 1);
                    if (exp_q.size() > 0) begin
                        n = exp_q.pop_front();
                        check("period_high", mon_hi, (n + 1) / 2);
                        check("period_low", mon_lo, n / 2);
                        check("period_div_cur", mon_dc, n);
                        check("period_shape", int'(mon_shape_bad), 0);
                        check("div_cur_stable", int'(mon_dc_bad), 0);
                    end
                    mon_open = 1'b0;
                end
                if (tick) begin
                    mon_open      = 1'b1;
                    mon_hi        = 0;
                    mon_lo        = 0;
                    mon_dc        = int'(div_cur);
                    mon_shape_bad = 1'b0;
                    mon_dc_bad    = 1'b0;
                end
                if (mon_open) begin
                    if (clk_out) begin
                        if (mon_lo > 0) mon_shape_bad = 1'b1;
                        mon_hi++;
                    end else begin
                        mon_lo++;
                    end
                    if (int'(div_cur) != mon_dc) mon_dc_bad = 1'b1;
                end else if (!busy) begin
                    check("idle_clk_out", int'(clk_out), 0);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int d_act[6];
        int d_k[6];
        int d_val[6];
        int act;
        int k;
        int val;

        d_act = '{0, 2, 1, 1, 0, 3};
        d_k   = '{0, 5, 3, 3, 0, 2};
        d_val = '{0, 1, 4, 15, 0, 0};
        n_cmp = 0;
        n_bad = 0;
        rst           = 1'b0;
        enable        = 1'b0;
        div_req_valid = 1'b0;
        div_req_val   = '0;
        repeat (3) step();
        check("rst_clk_out", int'(clk_out), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_err", int'(err_ratio), 0);
        check("rst_div_cur", int'(div_cur), 15);
        check("rst_ready", int'(div_req_ready), 0);
        rst = 1'b1;
        step();
        check("ready_after_release", int'(div_req_ready), 1);
        m_cur = 15;
        sched = 1'b0;
        do_restart();

        for (int p = 0; p < NPER; p++) begin
            wait_tick();
            if (sched && sched_p == p) begin
                m_cur = sched_val;
                sched = 1'b0;
            end
            exp_q.push_back(m_cur);
            if (p < 6) begin
                act = d_act[p];
                k   = d_k[p];
                val = d_val[p];
            end else begin
                act = int'($urandom_range(0, 3));
                k   = int'($urandom_range(0, m_cur - 1));
                val = int'($urandom_range(2, 20));
                if (act == 2) begin
                    val = int'($urandom_range(0, 1));
                    if (m_cur >= 4) k = int'($urandom_range(0, m_cur - 3));
                end
            end
            if ((act == 1 || act == 2) && sched) act = 0;
            if (act == 2 && m_cur < 4) act = 0;
            case (act)
                1: do_good_req(k, val, p);
                2: do_bad_req(k, val);
                3: begin
                    do_stop(k);
                    repeat ($urandom_range(0, 3)) step();
                    if ($urandom_range(0, 1) == 1) do_idle_req(int'($urandom_range(0, 12)));
                    do_restart();
                end
                default: step();
            endcase
        end

        wait_tick();
        if (sched) begin
            m_cur = sched_val;
            sched = 1'b0;
        end
        exp_q.push_back(m_cur);
        do_stop(0);
        do_idle_req(15);
        do_restart();
        exp_q.push_back(m_cur);
        repeat (4) step();
        check("pre_reset_high", int'(clk_out), 1);
        rst = 1'b0;
        step();
        check("midrst_clk_out", int'(clk_out), 0);
        check("midrst_busy", int'(busy), 0);
        check("midrst_tick", int'(tick), 0);
        check("midrst_div_cur", int'(div_cur), 15);
        check("midrst_ready", int'(div_req_ready), 0);
        rst = 1'b1;
        step();
        check("ready_after_midrst", int'(div_req_ready), 1);
        step();
        check("queue_drained", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
